traffic_phase_sequencer: RTL
============================

Name: traffic_phase_sequencer

Overview:
Two-road intersection controller. Sequences green/yellow/red lamps for road A and road B through a fixed six-phase cycle, with phase durations counted in one-second ticks. Exports the remaining phase time as two BCD digits that drive the existing seven-segment decoders directly. Accepts a pedestrian request that shortens the current green phase.

Parameters:
TICK_DIV, 50_000_000, clk cycles per one-second tick (>=2)
GREEN_S, 25, green duration in ticks (1..99)
YELLOW_S, 3, yellow duration in ticks (1..99)
ALL_RED_S, 2, all-red clearance duration in ticks (1..99)
PED_MIN_S, 5, green time left after a pedestrian request truncates the phase (1..GREEN_S)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ped_req  in  1  pedestrian request, level, sampled every clk
green_a  out  1  road A green lamp
yellow_a  out  1  road A yellow lamp
red_a  out  1  road A red lamp
green_b  out  1  road B green lamp
yellow_b  out  1  road B yellow lamp
red_b  out  1  road B red lamp
phase  out  3  current phase code
digit_tens  out  4  BCD tens of remaining ticks
digit_ones  out  4  BCD ones of remaining ticks
ped_ack  out  1  one-clk pulse when a pending request is consumed

Behaviour:
- Reset: reset is asynchronous, active-high; the clock is clk.
  - On reset: phase=ALL_RED_2, remain=ALL_RED_S, prescaler=0, ped_pending=0, ped_ack=0.
  - Lamp outputs during reset: red_a=red_b=1, all other lamps 0.
- Phase codes: A_GREEN=0, A_YELLOW=1, ALL_RED_1=2, B_GREEN=3, B_YELLOW=4, ALL_RED_2=5, FLASH=6 (optional feature only). Codes 7 and unused 6 recover to ALL_RED_2 on the next clk.
- Sequence: ALL_RED_2 -> A_GREEN -> A_YELLOW -> ALL_RED_1 -> B_GREEN -> B_YELLOW -> ALL_RED_2.
- Lamps are registered and decoded from phase.
  - Each road has exactly one lamp lit.
  - A lit green/yellow only in A_GREEN/A_YELLOW. B lit green/yellow only in B_GREEN/B_YELLOW. The other road is red in those phases.
  - Both roads are red in ALL_RED_1 and ALL_RED_2.
- Prescaler:
  - Free-running, counts 0..TICK_DIV-1.
  - tick=1 for one clk when count==TICK_DIV-1, then wraps to 0.
  - Not reset on phase change.
- Remain counter (7 bits), priority order per clk:
  1. tick && remain==1: advance phase, load the next phase's duration.
  2. Pedestrian truncation (below).
  3. tick: remain-1.
- Each phase lasts exactly its duration in ticks. Full cycle = 2*(GREEN_S+YELLOW_S+ALL_RED_S) ticks.
- Display: digit_tens=remain/10, digit_ones=remain%10, registered, updated in the same cycle as remain. Shows duration..1, never 0 during normal operation.
- Pedestrian handling:
  - ped_req=1 in any phase sets ped_pending.
  - In A_GREEN or B_GREEN with ped_pending=1:
    - If remain>PED_MIN_S: next clk remain<=PED_MIN_S.
    - If remain<=PED_MIN_S: remain unchanged.
    - In both cases ped_pending clears and ped_ack pulses for 1 clk.
  - A request seen in yellow or all-red stays pending and applies in the first clk of the next green.
  - ped_req held high re-arms pending immediately after ack. Because remain<=PED_MIN_S by then, there is no further effect in that green.
- Reset mid-operation: immediate return to the reset state; a pending request is discarded.

Optional Feature:
Macro TLS_NIGHT_FLASH_EN.
- Defined:
  - Adds input port night (1 bit).
  - night=1 is sampled at each phase advance point. Instead of the normal next phase, the block enters FLASH.
  - In FLASH:
    - yellow_a=yellow_b toggle on every tick, starting at 1; all other lamps 0.
    - digit_tens=digit_ones=4'hF, which the decoder blanks.
    - ped requests are ignored and pending is cleared without ack.
  - night=0 in FLASH: at the next tick, enter ALL_RED_2 with remain=ALL_RED_S.
- Undefined: no night port, FLASH is unreachable, code 6 recovers as invalid.

Test Plan:
Bench parameters: TICK_DIV=4, GREEN_S=12, YELLOW_S=3, ALL_RED_S=2, PED_MIN_S=5.
- Assert reset 3 clk, release -> red_a=red_b=1, phase=5, digits 0/2; after 8 clk phase=0, green_a=1, red_b=1, digits 1/2.
- Run 136 clk from first A_GREEN -> phases 0,1,2,3,4,5 lasting 48,12,8,48,12,8 clk; never two roads non-red simultaneously.
- ped_req pulse at A_GREEN remain=10 -> next clk remain=5 (digits 0/5), ped_ack 1 clk, phase 1 after exactly 20 further clk.
- ped_req pulse at A_GREEN remain=4 -> remain stays 4, ped_ack pulses, no timing change.
- ped_req pulse in A_YELLOW -> no ack until B_GREEN entry; 1 clk after entry remain 12->5, ped_ack pulses.
- Reset asserted mid B_GREEN remain=7 with ped pending -> immediately phase=5, red_a=red_b=1, digits 0/2; no ped_ack after release.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer
//   Two-road intersection controller. Steps the lamps of road A and road B
//   through a fixed six-phase cycle timed in one-second ticks. It exports the
//   remaining phase time as two BCD digits for the seven-segment decoders, and
//   a pedestrian request shortens the current green phase.
//
// Optional feature: define TLS_NIGHT_FLASH_EN to add the night-flash mode
//   (extra input 'night', phase code 6 = FLASH).
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   ped_req     in   pedestrian request (level, sampled every clk)
//   night       in   night-flash request (only with TLS_NIGHT_FLASH_EN)
//   green_a/yellow_a/red_a   out  road A lamps
//   green_b/yellow_b/red_b   out  road B lamps
//   phase       out  [2:0] current phase code
//   digit_tens  out  [3:0] BCD tens of remaining ticks
//   digit_ones  out  [3:0] BCD ones of remaining ticks
//   ped_ack     out  one-clk pulse when a pending request is consumed
//
// FSM states:
//   state      | meaning
//   A_GREEN  0 | road A green, road B red
//   A_YELLOW 1 | road A yellow, road B red
//   ALL_RED_1 2| clearance after road A
//   B_GREEN  3 | road B green, road A red
//   B_YELLOW 4 | road B yellow, road A red
//   ALL_RED_2 5| clearance after road B; reset state
//   FLASH    6 | night mode, both yellows blink (optional)
//   7 (and 6 without the option) recover to ALL_RED_2

module traffic_phase_sequencer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int GREEN_S   = 25,
  parameter int YELLOW_S  = 3,
  parameter int ALL_RED_S = 2,
  parameter int PED_MIN_S = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
`ifdef TLS_NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic       green_a,
  output logic       yellow_a,
  output logic       red_a,
  output logic       green_b,
  output logic       yellow_b,
  output logic       red_b,
  output logic [2:0] phase,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       ped_ack
);

  localparam logic [2:0] A_GREEN   = 3'd0;
  localparam logic [2:0] A_YELLOW  = 3'd1;
  localparam logic [2:0] ALL_RED_1 = 3'd2;
  localparam logic [2:0] B_GREEN   = 3'd3;
  localparam logic [2:0] B_YELLOW  = 3'd4;
  localparam logic [2:0] ALL_RED_2 = 3'd5;
  localparam logic [2:0] FLASH     = 3'd6;

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  localparam logic [6:0] GREEN_D   = 7'(GREEN_S);
  localparam logic [6:0] YELLOW_D  = 7'(YELLOW_S);
  localparam logic [6:0] ALL_RED_D = 7'(ALL_RED_S);
  localparam logic [6:0] PED_MIN_D = 7'(PED_MIN_S);

  // Lamp vector order: {green_a, yellow_a, red_a, green_b, yellow_b, red_b}
  localparam logic [5:0] LAMPS_ALL_RED = 6'b001_001;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    phase_q, phase_d;
  logic [6:0]    remain_q, remain_d;
  logic          ped_pending_q, ped_pending_d;
  logic          ped_ack_q, ped_ack_d;
  logic [5:0]    lamps_q, lamps_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
`ifdef TLS_NIGHT_FLASH_EN
  logic          flash_q, flash_d;
`endif

  logic          tick;
  logic          last_tick;
  logic          ped_eff;
  logic [2:0]    next_ph;

  function automatic logic [2:0] next_phase(input logic [2:0] p);
    case (p)
      A_GREEN:   next_phase = A_YELLOW;
      A_YELLOW:  next_phase = ALL_RED_1;
      ALL_RED_1: next_phase = B_GREEN;
      B_GREEN:   next_phase = B_YELLOW;
      B_YELLOW:  next_phase = ALL_RED_2;
      default:   next_phase = A_GREEN;
    endcase
  endfunction

  function automatic logic [6:0] dur_of(input logic [2:0] p);
    case (p)
      A_GREEN, B_GREEN:   dur_of = GREEN_D;
      A_YELLOW, B_YELLOW: dur_of = YELLOW_D;
      default:            dur_of = ALL_RED_D;
    endcase
  endfunction

  always_comb begin
    tick      = (presc_q == TICK_LAST);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    last_tick = tick && (remain_q == 7'd1);
    // A request on the same clk as a green cycle is acted on at once.
    ped_eff   = ped_pending_q | ped_req;
    next_ph   = next_phase(phase_q);

    phase_d       = phase_q;
    remain_d      = remain_q;
    ped_pending_d = ped_eff;
    ped_ack_d     = 1'b0;
`ifdef TLS_NIGHT_FLASH_EN
    flash_d       = flash_q;
`endif

    case (phase_q)
      A_GREEN, A_YELLOW, ALL_RED_1, B_GREEN, B_YELLOW, ALL_RED_2: begin
        if (last_tick) begin
`ifdef TLS_NIGHT_FLASH_EN
          if (night) begin
            phase_d       = FLASH;
            remain_d      = '0;
            flash_d       = 1'b1;
            ped_pending_d = 1'b0;
          end else begin
            phase_d  = next_ph;
            remain_d = dur_of(next_ph);
          end
`else
          phase_d  = next_ph;
          remain_d = dur_of(next_ph);
`endif
        end else if ((phase_q == A_GREEN || phase_q == B_GREEN) && ped_eff) begin
          if (remain_q > PED_MIN_D) remain_d = PED_MIN_D;
          ped_pending_d = 1'b0;
          ped_ack_d     = 1'b1;
        end else if (tick) begin
          remain_d = remain_q - 7'd1;
        end
      end
`ifdef TLS_NIGHT_FLASH_EN
      FLASH: begin
        ped_pending_d = 1'b0;
        if (tick) begin
          if (!night) begin
            phase_d  = ALL_RED_2;
            remain_d = ALL_RED_D;
            flash_d  = 1'b0;
          end else begin
            flash_d = ~flash_q;
          end
        end
      end
`endif
      default: begin
        phase_d  = ALL_RED_2;
        remain_d = ALL_RED_D;
      end
    endcase
  end

  // Lamps and digits are decoded from the next state so the registered
  // outputs line up with phase/remain on the same clk.
  always_comb begin
    lamps_d = LAMPS_ALL_RED;
    case (phase_d)
      A_GREEN:  lamps_d = 6'b100_001;
      A_YELLOW: lamps_d = 6'b010_001;
      B_GREEN:  lamps_d = 6'b001_100;
      B_YELLOW: lamps_d = 6'b001_010;
`ifdef TLS_NIGHT_FLASH_EN
      FLASH:    lamps_d = {1'b0, flash_d, 1'b0, 1'b0, flash_d, 1'b0};
`endif
      default:  lamps_d = LAMPS_ALL_RED;
    endcase

    tens_d = 4'(remain_d / 7'd10);
    ones_d = 4'(remain_d % 7'd10);
`ifdef TLS_NIGHT_FLASH_EN
    if (phase_d == FLASH) begin
      tens_d = 4'hF;
      ones_d = 4'hF;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      phase_q       <= ALL_RED_2;
      remain_q      <= ALL_RED_D;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
      lamps_q       <= LAMPS_ALL_RED;
      tens_q        <= 4'(ALL_RED_D / 7'd10);
      ones_q        <= 4'(ALL_RED_D % 7'd10);
    end else begin
      presc_q       <= presc_d;
      phase_q       <= phase_d;
      remain_q      <= remain_d;
      ped_pending_q <= ped_pending_d;
      ped_ack_q     <= ped_ack_d;
      lamps_q       <= lamps_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
    end
  end

`ifdef TLS_NIGHT_FLASH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flash_q <= 1'b0;
    else       flash_q <= flash_d;
  end
`endif

  assign {green_a, yellow_a, red_a, green_b, yellow_b, red_b} = lamps_q;
  assign phase      = phase_q;
  assign digit_tens = tens_q;
  assign digit_ones = ones_q;
  assign ped_ack    = ped_ack_q;

endmodule
